// File: rtl/miner_pkg.sv
// Shared constants for the miner register-file host bridge: opcodes, response codes,
// the park address and the bridge FSM state encoding.
package miner_pkg;

    localparam logic [7:0] OP_WR    = 8'hA5;
    localparam logic [7:0] OP_RD    = 8'hA6;
    localparam logic [7:0] OP_BURST = 8'hA7;

    localparam logic [7:0] RSP_ACK  = 8'h5A;
    localparam logic [7:0] RSP_NAK  = 8'hEE;

    // Unused address; parking here keeps nonce byte 1 (address 1) deselected.
    localparam logic [6:0] REG_PARK = 7'h7F;

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_ADDR      = 3'd1;
    localparam logic [2:0] ST_LEN       = 3'd2;
    localparam logic [2:0] ST_DATA      = 3'd3;
    localparam logic [2:0] ST_WRITE     = 3'd4;
    localparam logic [2:0] ST_RD_SET    = 3'd5;
    localparam logic [2:0] ST_RD_SAMPLE = 3'd6;
    localparam logic [2:0] ST_RESP      = 3'd7;

    // Burst address step: the low 7 bits wrap, an out-of-range bit 7 stays out of range.
    function automatic logic [7:0] addr_inc(input logic [7:0] a);
        return {a[7], a[6:0] + 7'd1};
    endfunction

endpackage

// File: rtl/bridge_timeout_ctr.sv
// Inter-byte idle timer for the host bridge; flags expiry on the last allowed idle cycle.
module bridge_timeout_ctr #(
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [W-1:0] LAST = W'(TIMEOUT_CYCLES - 1);

    logic [W-1:0] count;

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + 1'b1;
        end
    end

    assign expired = enable && !clear && (count == LAST);

endmodule

// File: rtl/reg_host_bridge.sv
// Host byte-stream initiator for the miner register file: single write, read and
// burst write commands, one response byte per command.
module reg_host_bridge
    import miner_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 100000,
    parameter int NUM_REGS       = 81,
    parameter int FIRST_RW       = 5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic       rx_ready,
    output logic [7:0] tx_data,
    output logic       tx_valid,
    input  logic       tx_ready,
    output logic [6:0] reg_num,
    output logic       reg_write,
    output logic [7:0] reg_wdata,
    input  logic [7:0] reg_rdata,
    output logic       busy
);

    logic [2:0] state;
    logic       is_rd;
    logic       is_burst;
    logic [7:0] addr;
    logic [7:0] len;
    logic       err;

    logic accept;
    logic tmr_clear;
    logic tmr_enable;
    logic tmr_expired;

    function automatic logic addr_exists(input logic [7:0] a);
        return a < 8'(NUM_REGS);
    endfunction

    function automatic logic addr_writable(input logic [7:0] a);
        return addr_exists(a) && (a >= 8'(FIRST_RW));
    endfunction

    assign rx_ready = (state == ST_IDLE) || (state == ST_ADDR) ||
                      (state == ST_LEN)  || (state == ST_DATA);
    assign accept   = rx_valid && rx_ready;
    assign tx_valid = (state == ST_RESP);
    assign busy     = (state != ST_IDLE);

    assign tmr_clear  = accept || (state == ST_IDLE) || (state == ST_RESP);
    assign tmr_enable = (state == ST_ADDR) || (state == ST_LEN) || (state == ST_DATA);

    bridge_timeout_ctr #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk    (clk),
        .reset  (reset),
        .clear  (tmr_clear),
        .enable (tmr_enable),
        .expired(tmr_expired)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            is_rd     <= 1'b0;
            is_burst  <= 1'b0;
            addr      <= '0;
            len       <= '0;
            err       <= 1'b0;
            tx_data   <= '0;
            reg_num   <= REG_PARK;
            reg_write <= 1'b0;
            reg_wdata <= '0;
        end else begin
            // NOTE: default-low here makes reg_write a single-cycle strobe without extra state.
            reg_write <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        err      <= 1'b0;
                        is_rd    <= (rx_data == OP_RD);
                        is_burst <= (rx_data == OP_BURST);
                        if (rx_data == OP_WR || rx_data == OP_RD || rx_data == OP_BURST) begin
                            state <= ST_ADDR;
                        end else begin
                            tx_data <= RSP_NAK;
                            state   <= ST_RESP;
                        end
                    end
                end
                ST_ADDR: begin
                    if (accept) begin
                        addr <= rx_data;
                        if (is_rd) begin
                            reg_num <= rx_data[6:0];
                            state   <= ST_RD_SET;
                        end else if (is_burst) begin
                            state <= ST_LEN;
                        end else begin
                            state <= ST_DATA;
                        end
                    end else if (tmr_expired) begin
                        state <= ST_IDLE;
                    end
                end
                ST_LEN: begin
                    if (accept) begin
                        len <= rx_data;
                        if (rx_data == 8'd0) begin
                            tx_data <= RSP_ACK;
                            state   <= ST_RESP;
                        end else begin
                            state <= ST_DATA;
                        end
                    end else if (tmr_expired) begin
                        state <= ST_IDLE;
                    end
                end
                ST_DATA: begin
                    // Strobe outputs are registered here so they are valid during WRITE.
                    if (accept) begin
                        if (addr_writable(addr)) begin
                            reg_num   <= addr[6:0];
                            reg_wdata <= rx_data;
                            reg_write <= 1'b1;
                        end else begin
                            err <= 1'b1;
                        end
                        state <= ST_WRITE;
                    end else if (tmr_expired) begin
                        state <= ST_IDLE;
                    end
                end
                ST_WRITE: begin
                    reg_num <= REG_PARK;
                    if (is_burst && len != 8'd1) begin
                        len   <= len - 8'd1;
                        addr  <= addr_inc(addr);
                        state <= ST_DATA;
                    end else begin
                        tx_data <= err ? RSP_NAK : RSP_ACK;
                        state   <= ST_RESP;
                    end
                end
                ST_RD_SET: begin
                    state <= ST_RD_SAMPLE;
                end
                ST_RD_SAMPLE: begin
                    tx_data <= addr_exists(addr) ? reg_rdata : 8'h00;
                    reg_num <= REG_PARK;
                    state   <= ST_RESP;
                end
                ST_RESP: begin
                    if (tx_ready) begin
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_reg_host_bridge.sv
// Directed bench for reg_host_bridge with a behavioural register file behind the byte port.
module tb_reg_host_bridge;

    localparam int TO = 64;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic [6:0] reg_num;
    logic       reg_write;
    logic [7:0] reg_wdata;
    logic [7:0] reg_rdata;
    logic       busy;

    int total = 0;
    int bad   = 0;

    logic [7:0] mem [0:127];
    logic [6:0] strobe_num [$];
    logic [7:0] strobe_data [$];
    int         tx_cycles = 0;

    always #5 clk = ~clk;

    reg_host_bridge #(
        .TIMEOUT_CYCLES(TO),
        .NUM_REGS      (81),
        .FIRST_RW      (5)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .rx_ready (rx_ready),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .reg_num  (reg_num),
        .reg_write(reg_write),
        .reg_wdata(reg_wdata),
        .reg_rdata(reg_rdata),
        .busy     (busy)
    );

    assign reg_rdata = mem[reg_num];

    always @(posedge clk) begin
        if (reg_write) begin
            mem[reg_num] <= reg_wdata;
            strobe_num.push_back(reg_num);
            strobe_data.push_back(reg_wdata);
        end
        if (tx_valid) tx_cycles <= tx_cycles + 1;
    end

    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        rx_data  = b;
        rx_valid = 1'b1;
        while (!rx_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!rx_ready) begin
            total++; bad++;
            $display("FAIL send_byte_ready got=0 want=1 byte=%h", b);
        end
        @(posedge clk);
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic get_resp(input string name, input logic [7:0] want);
        int n = 0;
        tx_ready = 1'b1;
        while (!tx_valid && n < 200) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (!tx_valid) begin
            bad++;
            $display("FAIL %s no response within bound", name);
        end else if (tx_data !== want) begin
            bad++;
            $display("FAIL %s tx_data got=%h want=%h", name, tx_data, want);
        end
        @(posedge clk);
        @(negedge clk);
        tx_ready = 1'b0;
    endtask

    task automatic check_strobes(input string name, input int want);
        total++;
        if (strobe_num.size() != want) begin
            bad++;
            $display("FAIL %s strobe_count got=%0d want=%0d", name, strobe_num.size(), want);
        end
    endtask

    task automatic check_reset_outputs(input string name);
        total++;
        if (rx_ready !== 1'b1 || tx_valid !== 1'b0 || tx_data !== 8'h00 || reg_write !== 1'b0 ||
            reg_wdata !== 8'h00 || reg_num !== 7'h7F || busy !== 1'b0) begin
            bad++;
            $display("FAIL %s got rdy=%b txv=%b txd=%h wr=%b wd=%h num=%h busy=%b want 1 0 00 0 00 7f 0",
                     name, rx_ready, tx_valid, tx_data, reg_write, reg_wdata, reg_num, busy);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset_values");
        reset = 1'b0;
        @(negedge clk);
        check_reset_outputs("idle_after_reset");
    endtask

    task automatic test_write();
        strobe_num.delete(); strobe_data.delete();
        send_byte(8'hA5); send_byte(8'h10); send_byte(8'h3C);
        get_resp("write_ack", 8'h5A);
        check_strobes("write", 1);
        if (strobe_num.size() == 1) begin
            total++;
            if (strobe_num[0] !== 7'h10 || strobe_data[0] !== 8'h3C) begin
                bad++;
                $display("FAIL write_strobe got=%h:%h want=10:3c", strobe_num[0], strobe_data[0]);
            end
        end
    endtask

    task automatic test_read();
        send_byte(8'hA6); send_byte(8'h10);
        total++;
        if (tx_valid !== 1'b0 || reg_num !== 7'h10) begin
            bad++;
            $display("FAIL read_set got txv=%b num=%h want 0 10", tx_valid, reg_num);
        end
        @(negedge clk);
        total++;
        if (tx_valid !== 1'b0 || reg_num !== 7'h10) begin
            bad++;
            $display("FAIL read_sample got txv=%b num=%h want 0 10", tx_valid, reg_num);
        end
        @(negedge clk);
        total++;
        if (tx_valid !== 1'b1 || tx_data !== 8'h3C || reg_num !== 7'h7F) begin
            bad++;
            $display("FAIL read_latency got txv=%b txd=%h num=%h want 1 3c 7f", tx_valid, tx_data, reg_num);
        end
        get_resp("read_data", 8'h3C);
    endtask

    task automatic test_burst();
        logic [6:0] wn [3] = '{7'h05, 7'h06, 7'h07};
        logic [7:0] wd [3] = '{8'h11, 8'h22, 8'h33};
        strobe_num.delete(); strobe_data.delete();
        send_byte(8'hA7); send_byte(8'h05); send_byte(8'h03);
        send_byte(8'h11); send_byte(8'h22); send_byte(8'h33);
        get_resp("burst_ack", 8'h5A);
        check_strobes("burst", 3);
        for (int i = 0; i < 3 && i < strobe_num.size(); i++) begin
            total++;
            if (strobe_num[i] !== wn[i] || strobe_data[i] !== wd[i]) begin
                bad++;
                $display("FAIL burst_strobe%0d got=%h:%h want=%h:%h", i, strobe_num[i], strobe_data[i], wn[i], wd[i]);
            end
        end
    endtask

    task automatic test_errors();
        strobe_num.delete(); strobe_data.delete();
        send_byte(8'hA5); send_byte(8'h02); send_byte(8'hFF);
        get_resp("write_ro_nak", 8'hEE);
        check_strobes("write_ro", 0);
        send_byte(8'hA5); send_byte(8'h04); send_byte(8'h44);
        get_resp("write_below_first_rw_nak", 8'hEE);
        send_byte(8'h00);
        get_resp("bad_opcode_nak", 8'hEE);
        send_byte(8'hA6); send_byte(8'h60);
        get_resp("read_oob_zero", 8'h00);
        send_byte(8'hA7); send_byte(8'h10); send_byte(8'h00);
        get_resp("burst_len0_ack", 8'h5A);
        check_strobes("ro_oob_len0", 0);
        // 0x4F and 0x50 are the last two writable registers; 0x51 is past the end.
        send_byte(8'hA7); send_byte(8'h4F); send_byte(8'h03);
        send_byte(8'hAA); send_byte(8'hBB); send_byte(8'hCC);
        get_resp("burst_edge_nak", 8'hEE);
        check_strobes("burst_edge", 2);
        if (strobe_num.size() == 2) begin
            total++;
            if (strobe_num[0] !== 7'h4F || strobe_data[0] !== 8'hAA ||
                strobe_num[1] !== 7'h50 || strobe_data[1] !== 8'hBB) begin
                bad++;
                $display("FAIL burst_edge_strobes got=%h:%h %h:%h want=4f:aa 50:bb",
                         strobe_num[0], strobe_data[0], strobe_num[1], strobe_data[1]);
            end
        end
    endtask

    task automatic test_timeout();
        int tx_before;
        strobe_num.delete(); strobe_data.delete();
        tx_before = tx_cycles;
        send_byte(8'hA5); send_byte(8'h10);
        repeat (TO - 1) @(negedge clk);
        total++;
        if (busy !== 1'b1) begin
            bad++;
            $display("FAIL timeout_early got busy=%b want=1", busy);
        end
        @(negedge clk);
        total++;
        if (busy !== 1'b0 || rx_ready !== 1'b1) begin
            bad++;
            $display("FAIL timeout_abort got busy=%b rdy=%b want 0 1", busy, rx_ready);
        end
        total++;
        if (tx_cycles != tx_before) begin
            bad++;
            $display("FAIL timeout_no_tx got=%0d want=%0d", tx_cycles, tx_before);
        end
        check_strobes("timeout", 0);
        send_byte(8'hA6); send_byte(8'h10);
        get_resp("read_after_timeout", 8'h3C);
    endtask

    task automatic test_back_pressure();
        int n = 0;
        int unstable = 0;
        logic [7:0] held;
        send_byte(8'hA5); send_byte(8'h20); send_byte(8'h77);
        while (!tx_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        held = tx_data;
        rx_data  = 8'h00;
        rx_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (tx_valid !== 1'b1 || tx_data !== held || rx_ready !== 1'b0) unstable++;
        end
        total++;
        if (unstable != 0 || held !== 8'h5A) begin
            bad++;
            $display("FAIL stall_hold got unstable=%0d held=%h want 0 5a", unstable, held);
        end
        get_resp("stall_release", 8'h5A);
        // The opcode held on rx during the stall is consumed only once IDLE is reached.
        @(posedge clk);
        @(negedge clk);
        rx_valid = 1'b0;
        get_resp("held_byte_consumed", 8'hEE);
    endtask

    task automatic test_reset_mid_burst();
        strobe_num.delete(); strobe_data.delete();
        send_byte(8'hA7); send_byte(8'h30); send_byte(8'h04);
        send_byte(8'h01); send_byte(8'h02);
        rx_data  = 8'h03;
        rx_valid = 1'b1;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check_reset_outputs("reset_mid_burst");
        reset    = 1'b0;
        rx_valid = 1'b0;
        @(negedge clk);
        check_strobes("reset_mid_burst", 2);
        total++;
        if (mem[7'h32] !== 8'h00) begin
            bad++;
            $display("FAIL reset_no_strobe got mem32=%h want=00", mem[7'h32]);
        end
    endtask

    initial begin
        for (int i = 0; i < 128; i++) mem[i] = 8'h00;
        reset    = 1'b1;
        rx_data  = 8'h00;
        rx_valid = 1'b0;
        tx_ready = 1'b0;
        test_reset();
        test_write();
        test_read();
        test_burst();
        test_errors();
        test_timeout();
        test_back_pressure();
        test_reset_mid_burst();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
